// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - byte-serial load/store sequencer for the shared byte-wide memory bus
//
// Accepts one byte/half/word load or store and issues it as consecutive
// little-endian byte accesses using a request/grant handshake. Load bytes are
// assembled into rdata_o, with optional sign extension, and done_o pulses once.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   rdy              global ready; low freezes every register
//   req_i            start a transaction (sampled only while idle)
//   we_i             1 = store, 0 = load
//   size_i           00 byte, 01 half, 10/11 word
//   sign_ext_i       sign-extend byte/half loads
//   addr_i           base byte address
//   wdata_i          store data, byte k goes to addr_i+k
//   grant_i          arbiter grants the bus this cycle
//   mem_din_i        read byte, valid one cycle after its granted address
//   mem_req_o        bus request
//   mem_we_o         write enable for the current byte
//   mem_addr_o       current byte address
//   mem_dout_o       current write byte
//   busy_o           transaction in progress
//   done_o           one-cycle completion pulse
//   rdata_o          load result, held until the next accepted request
module mem_access_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [1:0]        size_i,
    input  logic              sign_ext_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              grant_i,
    input  logic [7:0]        mem_din_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_dout_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] rdata_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_TAIL,
        S_DONE
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic                we_q;
    logic                sx_q;
    logic [1:0]          size_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [2:0]          issue_cnt;
    logic [2:0]          recv_cnt;
    logic                cap_pend;
    logic [DATA_W-1:0]   rdata_q;

    logic [2:0]          n_bytes;
    logic                issue;
    logic [DATA_W-1:0]   rdata_cap;
    logic [DATA_W-1:0]   rdata_ext;

    always_comb begin
        case (size_q)
            2'b00:   n_bytes = 3'd1;
            2'b01:   n_bytes = 3'd2;
            default: n_bytes = 3'd4;
        endcase
    end

    always_comb begin
        state_nxt  = state;
        mem_req_o  = 1'b0;
        mem_we_o   = 1'b0;
        mem_addr_o = '0;
        mem_dout_o = 8'h00;
        issue      = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_i) begin
                    state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                mem_req_o  = 1'b1;
                mem_we_o   = we_q;
                // Address wraps naturally modulo 2^ADDR_W.
                mem_addr_o = addr_q + ADDR_W'(issue_cnt);
                if (we_q) begin
                    mem_dout_o = wdata_q[{issue_cnt[1:0], 3'b000} +: 8];
                end
                issue = grant_i;
                if (grant_i && (issue_cnt + 3'd1 == n_bytes)) begin
                    // Loads need one more cycle to capture the final returned byte.
                    state_nxt = we_q ? S_DONE : S_TAIL;
                end
            end
            S_TAIL: begin
                state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Merge the pending read byte into its lane, then build the extended
    // version used when the last byte lands on the way into DONE.
    always_comb begin
        rdata_cap = rdata_q;
        if (cap_pend) begin
            rdata_cap[{recv_cnt[1:0], 3'b000} +: 8] = mem_din_i;
        end
        rdata_ext = rdata_cap;
        case (size_q)
            2'b00:   rdata_ext[31:8]  = sx_q ? {24{rdata_cap[7]}} : 24'h0;
            2'b01:   rdata_ext[31:16] = sx_q ? {16{rdata_cap[15]}} : 16'h0;
            default: rdata_ext = rdata_cap;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            we_q      <= 1'b0;
            sx_q      <= 1'b0;
            size_q    <= 2'b00;
            addr_q    <= '0;
            wdata_q   <= '0;
            issue_cnt <= 3'd0;
            recv_cnt  <= 3'd0;
            cap_pend  <= 1'b0;
            rdata_q   <= '0;
        end else if (rdy) begin
            state    <= state_nxt;
            // A granted load byte returns on mem_din_i in the following cycle.
            cap_pend <= issue & ~we_q;
            if (state == S_IDLE && req_i) begin
                we_q      <= we_i;
                sx_q      <= sign_ext_i;
                size_q    <= size_i;
                addr_q    <= addr_i;
                wdata_q   <= wdata_i;
                issue_cnt <= 3'd0;
                recv_cnt  <= 3'd0;
                rdata_q   <= '0;
            end else begin
                if (issue) begin
                    issue_cnt <= issue_cnt + 3'd1;
                end
                if (cap_pend) begin
                    recv_cnt <= recv_cnt + 3'd1;
                    rdata_q  <= (state == S_TAIL) ? rdata_ext : rdata_cap;
                end
            end
        end
    end

    assign busy_o  = (state != S_IDLE);
    assign done_o  = (state == S_DONE);
    assign rdata_o = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b1;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [1:0]  size_i = 2'b00;
    logic        sign_ext_i = 1'b0;
    logic [31:0] addr_i = 32'h0;
    logic [31:0] wdata_i = 32'h0;
    logic        grant_i = 1'b0;
    logic [7:0]  mem_din_i = 8'h00;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [7:0]  mem_dout_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] rdata_o;

    logic [7:0]  ram [0:255];

    int checks = 0;
    int errors = 0;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rdy        (rdy),
        .req_i      (req_i),
        .we_i       (we_i),
        .size_i     (size_i),
        .sign_ext_i (sign_ext_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .grant_i    (grant_i),
        .mem_din_i  (mem_din_i),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_dout_o (mem_dout_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .rdata_o    (rdata_o)
    );

    always #5 clk = ~clk;

    // Byte-wide memory indexed by the low address byte; read data appears
    // one cycle after a granted read and holds while rdy is low.
    always @(posedge clk) begin
        if (rdy && mem_req_o && grant_i) begin
            if (mem_we_o) ram[mem_addr_o[7:0]] <= mem_dout_o;
            else          mem_din_i <= ram[mem_addr_o[7:0]];
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic sx);
        logic [31:0] v;
        logic [31:0] ak;
        int n;
        n = nbytes(sz);
        v = 32'h0;
        for (int k = 0; k < n; k++) begin
            ak = a + 32'(k);
            v = v | ({24'h0, ram[ak[7:0]]} << (8 * k));
        end
        if (sx && n == 1 && v[7])  v = v | 32'hFFFFFF00;
        if (sx && n == 2 && v[15]) v = v | 32'hFFFF0000;
        return v;
    endfunction

    // Runs one transaction from an idle cycle (that cycle is cycle 0).
    // gmode: 0 grant always, 1 random grant, 2 grant low in cycles 2-3.
    // rdy is held low for rn cycles starting at cycle rs.
    task automatic run_txn(input logic we, input logic [1:0] sz, input logic sx,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int gmode, input int rs, input int rn,
                           output int lat, output logic [31:0] rd,
                           output int stalls, output int nb);
        int cyc;
        bit fin;
        we_i = we; size_i = sz; sign_ext_i = sx; addr_i = addr; wdata_i = wd;
        req_i = 1'b1; grant_i = 1'b0; rdy = 1'b1;
        tick();
        cyc = 1; nb = 0; stalls = 0; lat = -1; rd = 32'h0; fin = 0;
        while (!fin && cyc < 80) begin
            // Garbage on the request side must be ignored while busy.
            we_i = 1'($urandom_range(0, 1));
            size_i = 2'($urandom_range(0, 3));
            sign_ext_i = 1'($urandom_range(0, 1));
            addr_i = $urandom;
            wdata_i = $urandom;
            rdy = !(cyc >= rs && cyc < rs + rn);
            case (gmode)
                0:       grant_i = 1'b1;
                1:       grant_i = 1'($urandom_range(0, 1));
                default: grant_i = !(cyc == 2 || cyc == 3);
            endcase
            #1;
            if (done_o) begin
                fin = 1;
                lat = cyc;
                rd = rdata_o;
                req_i = 1'b1;
            end else begin
                req_i = 1'($urandom_range(0, 1));
                if (rdy && mem_req_o && grant_i) begin
                    chk("bus_addr", mem_addr_o, addr + 32'(nb));
                    chk("bus_we", {31'h0, mem_we_o}, {31'h0, we});
                    chk("bus_dout", {24'h0, mem_dout_o}, we ? ((wd >> (8 * nb)) & 32'hFF) : 32'h0);
                    nb++;
                end else begin
                    if (mem_req_o) chk("bus_addr_hold", mem_addr_o, addr + 32'(nb));
                    if (!rdy || mem_req_o) stalls++;
                end
            end
            tick();
            cyc++;
        end
        req_i = 1'b0;
        rdy = 1'b1;
        if (!fin) chk("done_timeout", 32'h0, 32'h1);
        chk("post_done_idle", {30'h0, busy_o, done_o}, 32'h0);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        sx;
        logic [31:0] addr;
        logic [31:0] wd;
        int          gmode;
        int          rs;
        int          rn;
        logic [31:0] exp_rd;
        int          exp_lat;
    } vec_t;

    vec_t vt [14];

    initial begin
        int lat, stalls, nb, dones, n;
        logic [31:0] rd, exp_rd;
        logic        we, sx;
        logic [1:0]  sz;
        logic [31:0] addr, wd;

        vt[0]  = '{1'b1, 2'b10, 1'b0, 32'h00001000, 32'h44332211, 0, 0, 0, 32'h0,        5};
        vt[1]  = '{1'b0, 2'b10, 1'b0, 32'h00001000, 32'h0,        0, 0, 0, 32'h44332211, 6};
        vt[2]  = '{1'b1, 2'b01, 1'b0, 32'h00000FFF, 32'h0000BEEF, 0, 0, 0, 32'h0,        3};
        vt[3]  = '{1'b0, 2'b01, 1'b1, 32'h00000FFF, 32'h0,        0, 0, 0, 32'hFFFFBEEF, 4};
        vt[4]  = '{1'b0, 2'b01, 1'b0, 32'h00000FFF, 32'h0,        0, 0, 0, 32'h0000BEEF, 4};
        vt[5]  = '{1'b1, 2'b00, 1'b0, 32'h00000020, 32'h00000080, 0, 0, 0, 32'h0,        2};
        vt[6]  = '{1'b1, 2'b00, 1'b1, 32'h00000021, 32'h0000007F, 0, 0, 0, 32'h0,        2};
        vt[7]  = '{1'b0, 2'b00, 1'b1, 32'h00000020, 32'h0,        0, 0, 0, 32'hFFFFFF80, 3};
        vt[8]  = '{1'b0, 2'b00, 1'b0, 32'h00000020, 32'h0,        0, 0, 0, 32'h00000080, 3};
        vt[9]  = '{1'b0, 2'b00, 1'b1, 32'h00000021, 32'h0,        0, 0, 0, 32'h0000007F, 3};
        vt[10] = '{1'b1, 2'b11, 1'b0, 32'hFFFFFFFE, 32'hA1B2C3D4, 0, 0, 0, 32'h0,        5};
        vt[11] = '{1'b0, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h0,        0, 0, 0, 32'hA1B2C3D4, 6};
        vt[12] = '{1'b0, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h0,        2, 0, 0, 32'hA1B2C3D4, 8};
        vt[13] = '{1'b0, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h0,        0, 2, 3, 32'hA1B2C3D4, 9};

        for (int i = 0; i < 256; i++) ram[i] = 8'h00;

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        chk("reset_mem_req", {31'h0, mem_req_o}, 32'h0);
        chk("reset_mem_we", {31'h0, mem_we_o}, 32'h0);
        chk("reset_mem_addr", mem_addr_o, 32'h0);
        chk("reset_mem_dout", {24'h0, mem_dout_o}, 32'h0);
        chk("reset_busy_done", {30'h0, busy_o, done_o}, 32'h0);
        chk("reset_rdata", rdata_o, 32'h0);
        rst_n = 1'b1;
        tick();

        // Directed table
        for (int i = 0; i < 14; i++) begin
            run_txn(vt[i].we, vt[i].sz, vt[i].sx, vt[i].addr, vt[i].wd,
                    vt[i].gmode, vt[i].rs, vt[i].rn, lat, rd, stalls, nb);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vt[i].exp_lat));
            chk($sformatf("vec%0d_nbytes", i), 32'(nb), 32'(nbytes(vt[i].sz)));
            if (!vt[i].we) begin
                chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
                chk($sformatf("vec%0d_rdata_hold", i), rdata_o, vt[i].exp_rd);
            end
        end

        // Reset in cycle 2 of a word load discards it immediately
        we_i = 1'b0; size_i = 2'b10; sign_ext_i = 1'b0; addr_i = 32'h00002000;
        req_i = 1'b1; grant_i = 1'b1;
        tick();
        req_i = 1'b0;
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        chk("midreset_mem_req", {31'h0, mem_req_o}, 32'h0);
        chk("midreset_busy", {31'h0, busy_o}, 32'h0);
        tick();
        rst_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (done_o || busy_o) dones++;
        end
        chk("midreset_no_done", 32'(dones), 32'h0);
        exp_rd = model_load(32'h00000FFF, 2'b10, 1'b0);
        run_txn(1'b0, 2'b10, 1'b0, 32'h00000FFF, 32'h0, 0, 0, 0, lat, rd, stalls, nb);
        chk("after_reset_latency", 32'(lat), 32'd6);
        chk("after_reset_rdata", rd, exp_rd);

        // Randomized transactions against the reference model
        for (int t = 0; t < 40; t++) begin
            we = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            sx = 1'($urandom_range(0, 1));
            addr = $urandom;
            wd = $urandom;
            n = nbytes(sz);
            exp_rd = model_load(addr, sz, sx);
            run_txn(we, sz, sx, addr, wd, 1, 0, 0, lat, rd, stalls, nb);
            chk($sformatf("rnd%0d_nbytes", t), 32'(nb), 32'(n));
            chk($sformatf("rnd%0d_latency", t), 32'(lat), 32'(n + (we ? 1 : 2) + stalls));
            if (!we) chk($sformatf("rnd%0d_rdata", t), rd, exp_rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Requester-side sequencer for the shared byte-wide memory bus. It sits between a pipeline stage (IF or MEM) and the bus arbiter.
- It accepts one byte/half/word load or store, then issues it as consecutive little-endian byte accesses with a request/grant handshake.
- For loads, it assembles returned bytes into a 32-bit result (with optional sign extension) and pulses done.

Parameters:
- ADDR_W, 32, bus address width
- DATA_W, 32, pipeline-side data width (fixed at 4 bytes)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rdy  in  1  global ready; low freezes all state
- req_i  in  1  start a transaction; sampled only in IDLE
- we_i  in  1  1 = store, 0 = load
- size_i  in  2  00 byte, 01 half, 10 word; 11 treated as word
- sign_ext_i  in  1  sign-extend byte/half loads
- addr_i  in  32  base byte address
- wdata_i  in  32  store data; byte k goes to addr_i+k
- grant_i  in  1  arbiter owns bus for this requester this cycle
- mem_din_i  in  8  read byte, valid one cycle after its granted address
- mem_req_o  out  1  bus request
- mem_we_o  out  1  write enable for the current byte
- mem_addr_o  out  32  current byte address
- mem_dout_o  out  8  current write byte
- busy_o  out  1  transaction in progress (state != IDLE)
- done_o  out  1  one-cycle completion pulse
- rdata_o  out  32  load result; held until the next accepted request

Behaviour:
- Reset (async, rst_n=0): state IDLE; all counters 0; all outputs 0, including rdata_o.
- rdy=0: every register holds its value; outputs reflect held state; no capture, no count advance.
- Latched on acceptance: we, size, sign_ext, addr, wdata. Byte count n = 1/2/4.
- Counters:
  - issue_cnt, 0..4: bytes issued.
  - recv_cnt, 0..4: bytes captured.
  - cap_pend flag = registered (grant_i & mem_req_o & !we).
- States:
  - IDLE: req_i=1 latches the request and enters ACCESS next cycle. Outputs mem_req_o=0, busy_o=0.
  - ACCESS:
    - mem_req_o=1, mem_we_o=we.
    - mem_addr_o = base + issue_cnt, mod 2^32; wrap from FFFFFFFF to 00000000 is legal.
    - mem_dout_o = wdata byte[issue_cnt] for stores, 00 for loads.
    - grant_i=1: issue_cnt increments. grant_i=0: address and data hold and nothing advances.
    - When the final byte is granted: stores go to DONE; loads go to TAIL.
  - TAIL (loads only): mem_req_o=0; captures the last byte; goes to DONE.
  - DONE: done_o=1 for exactly one cycle, rdata_o valid; next state IDLE.
- Load capture: whenever cap_pend=1 (ACCESS or TAIL), mem_din_i is written into rdata byte lane recv_cnt and recv_cnt increments. Byte issued with grant in cycle N is captured in cycle N+1.
- Load extension, applied when entering DONE:
  - Byte: bits 31:8 = sign_ext ? bit7 : 0.
  - Half: bits 31:16 = sign_ext ? bit15 : 0.
  - Word: unchanged.
- Latency with continuous grant, request accepted in cycle 0:
  - Word load: done_o in cycle 6.
  - Word store: done_o in cycle 5.
  - Byte load: done_o in cycle 3.
  - Each cycle of withheld grant adds one cycle.
- req_i while busy_o=1 is ignored; there is no queueing. req_i in the DONE cycle is also ignored.
- Grant withdrawn mid-transaction: byte order and addresses remain contiguous; no byte is skipped or duplicated.
- Misaligned addresses are legal; there are no alignment faults.
- Reset asserted mid-transaction: transaction is discarded immediately; mem_req_o drops asynchronously; no done_o.

Test Plan:
- Word load at 0x00001000, grant always 1, RAM bytes 11,22,33,44 -> mem_addr_o 1000..1003 in cycles 1-4; done_o in cycle 6; rdata_o=44332211.
- Half store 0xBEEF at 0x00000FFF, grant 1 -> writes EF@0FFF, BE@1000, mem_we_o=1 both cycles; done_o in cycle 3.
- Byte load of 0x80, sign_ext=1, then the same byte with sign_ext=0 -> rdata_o=FFFFFF80, then 00000080.
- Word load with grant_i low in cycles 2-3 -> mem_addr_o holds base+1 through cycle 3; rdata correct; done_o in cycle 8.
- Address wrap: word store at FFFFFFFE -> addresses FFFFFFFE, FFFFFFFF, 00000000, 00000001.
- rst_n pulsed low in cycle 2 of a word load -> mem_req_o=0, busy_o=0 immediately, no done_o; a new request afterwards completes normally. rdy=0 for 3 cycles mid-load -> completion delayed by exactly 3 cycles.
